// File: rtl/cim_noc_pkg.sv
// Shared flit-format definitions and route FSM states for the CIM packet switch.
package cim_noc_pkg;

    localparam logic [1:0] FT_BODY   = 2'b00;
    localparam logic [1:0] FT_HEAD   = 2'b01;
    localparam logic [1:0] FT_TAIL   = 2'b10;
    localparam logic [1:0] FT_SINGLE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } route_st_e;

    // Both helpers take the three flit MSBs: {type[1:0], dest}.
    function automatic logic [1:0] flit_type(input logic [2:0] flit);
        return flit[2:1];
    endfunction

    function automatic logic flit_dest(input logic [2:0] flit);
        return flit[0];
    endfunction

endpackage

// File: rtl/cim_noc_system_flit_fifo.sv
// First-word fall-through flit FIFO; head reads as zero while empty.
module flit_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [DW-1:0] data_i,
    input  logic          pop_i,
    output logic [DW-1:0] data_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int AW = $clog2(DEPTH);

    // Pointers carry one wrap bit so full and empty are distinguishable.
    logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic          do_push, do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign wptr_d  = wptr_q + {{AW{1'b0}}, do_push};
    assign rptr_d  = rptr_q + {{AW{1'b0}}, do_pop};
    assign data_o  = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/cim_noc_system.sv
// Wormhole packet switch: one source stream routed to two sink FIFOs.
// Optional per-port delivered-packet counters under CIM_PKT_CNT_EN.
module cim_noc_system
    import cim_noc_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] data_i_stab,
    input  logic          valid_i_stab,
    output logic          ready_o_stab,
    output logic [DW-1:0] data_o_flee0,
    output logic [DW-1:0] data_o_flee1,
    output logic          valid_o_flee0,
    output logic          valid_o_flee1,
    input  logic          ready_i_flee0,
    input  logic          ready_i_flee1
`ifdef CIM_PKT_CNT_EN
    ,
    output logic [31:0]   pkt_cnt_flee0,
    output logic [31:0]   pkt_cnt_flee1
`endif
);
    route_st_e  state_q, state_d;
    logic [1:0] ftype;
    logic       fdest, rdy, acc;
    logic [1:0] push, full, empty;

    assign ftype = flit_type(data_i_stab[DW-1 -: 3]);
    assign fdest = flit_dest(data_i_stab[DW-1 -: 3]);
    assign acc   = valid_i_stab & rdy;
    assign ready_o_stab = rdy & ~rst;

    always_comb begin
        state_d = state_q;
        push    = '0;
        rdy     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (ftype == FT_HEAD || ftype == FT_SINGLE) begin
                    rdy = ~full[fdest];
                    if (acc) begin
                        push[fdest] = 1'b1;
                        if (ftype == FT_HEAD) state_d = fdest ? ST_LOCK1 : ST_LOCK0;
                    end
                end else begin
                    rdy = 1'b1;  // stray body/tail: swallow it
                end
            end
            ST_LOCK0, ST_LOCK1: begin
                rdy = ~full[state_q == ST_LOCK1];
                if (acc) begin
                    push[state_q == ST_LOCK1] = 1'b1;
                    if (ftype == FT_TAIL) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    flit_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo0 (
        .clk(clk), .rst(rst), .push_i(push[0]), .data_i(data_i_stab),
        .pop_i(ready_i_flee0), .data_o(data_o_flee0), .full_o(full[0]), .empty_o(empty[0])
    );

    flit_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo1 (
        .clk(clk), .rst(rst), .push_i(push[1]), .data_i(data_i_stab),
        .pop_i(ready_i_flee1), .data_o(data_o_flee1), .full_o(full[1]), .empty_o(empty[1])
    );

    assign valid_o_flee0 = ~empty[0];
    assign valid_o_flee1 = ~empty[1];

`ifdef CIM_PKT_CNT_EN
    logic [31:0] cnt0_q, cnt1_q;
    logic        eop0, eop1;
    logic [1:0]  otype0, otype1;

    assign otype0 = flit_type(data_o_flee0[DW-1 -: 3]);
    assign otype1 = flit_type(data_o_flee1[DW-1 -: 3]);
    assign eop0 = valid_o_flee0 & ready_i_flee0 & (otype0 == FT_TAIL || otype0 == FT_SINGLE);
    assign eop1 = valid_o_flee1 & ready_i_flee1 & (otype1 == FT_TAIL || otype1 == FT_SINGLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (eop0) cnt0_q <= cnt0_q + 32'd1;
            if (eop1) cnt1_q <= cnt1_q + 32'd1;
        end
    end

    assign pkt_cnt_flee0 = cnt0_q;
    assign pkt_cnt_flee1 = cnt1_q;
`endif

endmodule

// File: tb/tb_cim_noc_system.sv
// Self-checking bench for cim_noc_system: directed tables, corner sequences, random traffic.
module tb_cim_noc_system;
    import cim_noc_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] din;
    logic          vin, rdy_stab;
    logic [DW-1:0] d0, d1;
    logic          v0, v1, r0, r1;
`ifdef CIM_PKT_CNT_EN
    logic [31:0]   pc0, pc1;
`endif

    cim_noc_system #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .data_i_stab(din), .valid_i_stab(vin), .ready_o_stab(rdy_stab),
        .data_o_flee0(d0), .data_o_flee1(d1),
        .valid_o_flee0(v0), .valid_o_flee1(v1),
        .ready_i_flee0(r0), .ready_i_flee1(r1)
`ifdef CIM_PKT_CNT_EN
        , .pkt_cnt_flee0(pc0), .pkt_cnt_flee1(pc1)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int cyc = 0;
    // reference model: locked port (-1 = idle), per-port FIFO contents, delivered logs
    int mstate = -1;
    logic [31:0] q0[$], q1[$], log0[$], log1[$];
    int   cnt0 = 0, cnt1 = 0, pkts = 0;
    bit   last_acc, rand_rdy = 0, throttle0 = 0;
    logic s_v0, s_v1, s_rdy;
    logic [31:0] s_d0, s_d1;

    typedef struct { logic [31:0] flit; int port; } vec_t;  // port 2 = dropped
    vec_t vt[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int qsize(input int p);
        return (p == 0) ? q0.size() : q1.size();
    endfunction

    function automatic void qpush(input int p, input logic [31:0] f);
        if (p == 0) q0.push_back(f); else q1.push_back(f);
    endfunction

    // one clock: check outputs at negedge, advance model, return at posedge+1
    task automatic cycle();
        logic er;
        logic [1:0] t;
        int dd;
        @(negedge clk);
        s_v0 = v0; s_v1 = v1; s_d0 = d0; s_d1 = d1; s_rdy = rdy_stab;
        chk("valid0", {31'd0, v0}, {31'd0, q0.size() != 0});
        if (q0.size() != 0) chk("data0", d0, q0[0]);
        chk("valid1", {31'd0, v1}, {31'd0, q1.size() != 0});
        if (q1.size() != 0) chk("data1", d1, q1[0]);
        t  = din[31:30];
        dd = int'(din[29]);
        if (mstate < 0) er = (t == FT_HEAD || t == FT_SINGLE) ? (qsize(dd) < DEPTH) : 1'b1;
        else            er = qsize(mstate) < DEPTH;
        chk("ready_stab", {31'd0, rdy_stab}, {31'd0, er});
        last_acc = vin & er;
        if (q0.size() != 0 && r0) begin
            log0.push_back(q0[0]);
            if (q0[0][31:30] == FT_TAIL || q0[0][31:30] == FT_SINGLE) cnt0++;
            void'(q0.pop_front());
        end
        if (q1.size() != 0 && r1) begin
            log1.push_back(q1[0]);
            if (q1[0][31:30] == FT_TAIL || q1[0][31:30] == FT_SINGLE) cnt1++;
            void'(q1.pop_front());
        end
        if (last_acc) begin
            if (mstate >= 0) begin
                qpush(mstate, din);
                if (t == FT_TAIL) mstate = -1;
            end else if (t == FT_HEAD) begin
                qpush(dd, din);
                mstate = dd;
            end else if (t == FT_SINGLE) begin
                qpush(dd, din);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rand_rdy) begin
            r0 = ($urandom_range(0, 3) != 0);
            r1 = ($urandom_range(0, 3) != 0);
        end else if (throttle0) begin
            r0 = (cyc % 16 == 0);
        end
    endtask

    task automatic send(input logic [31:0] f);
        int n = 0;
        din = f;
        vin = 1'b1;
        do begin cycle(); n++; end while (!last_acc && n < 3000);
        if (!last_acc) begin
            checks++; failures++;
            $display("FAIL send_timeout flit=%h not accepted within %0d cycles", f, n);
        end
        vin = 1'b0;
    endtask

    task automatic idle(input int n);
        vin = 1'b0;
        repeat (n) cycle();
    endtask

    task automatic drain(input int bound);
        int n = 0;
        vin = 1'b0;
        while ((q0.size() != 0 || q1.size() != 0) && n < bound) begin cycle(); n++; end
        chk("drain_left", q0.size() + q1.size(), 0);
    endtask

    initial begin
        logic [31:0] exp_pkt[$];
        logic [31:0] f;
        logic [28:0] pay;
        int len, dst, flits;

        vt[0] = '{32'hE000_0001, 1};
        vt[1] = '{32'hC000_0002, 0};
        vt[2] = '{32'h2000_0003, 2};
        vt[3] = '{32'h8000_0004, 2};
        vt[4] = '{32'hC123_4567, 0};
        vt[5] = '{32'hFFFF_FFFF, 1};

        rst = 1'b1; vin = 1'b0; din = '0; r0 = 1'b1; r1 = 1'b1;
        #1;
        chk("rst_ready", {31'd0, rdy_stab}, 32'd0);
        chk("rst_v0", {31'd0, v0}, 32'd0);
        chk("rst_v1", {31'd0, v1}, 32'd0);
        chk("rst_d0", d0, 32'd0);
        chk("rst_d1", d1, 32'd0);
`ifdef CIM_PKT_CNT_EN
        chk("rst_pc0", pc0, 32'd0);
        chk("rst_pc1", pc1, 32'd0);
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // directed singles and strays: visible one cycle after accept, or never
        foreach (vt[i]) begin
            send(vt[i].flit);
            cycle();
            chk("tbl_v0", {31'd0, s_v0}, {31'd0, vt[i].port == 0});
            chk("tbl_v1", {31'd0, s_v1}, {31'd0, vt[i].port == 1});
            if (vt[i].port == 0) chk("tbl_d0", s_d0, vt[i].flit);
            if (vt[i].port == 1) chk("tbl_d1", s_d1, vt[i].flit);
        end

        // wormhole lock: body with dest bit set still follows the head
        log0.delete(); log1.delete();
        send(32'h6000_0000); send(32'h2000_00AA); send(32'h8000_00BB);
        idle(3);
        chk("worm_len1", log1.size(), 3);
        chk("worm_len0", log0.size(), 0);
        if (log1.size() == 3) begin
            chk("worm_f0", log1[0], 32'h6000_0000);
            chk("worm_f1", log1[1], 32'h2000_00AA);
            chk("worm_f2", log1[2], 32'h8000_00BB);
        end

        // backpressure: 20-flit packet to stalled flee0
        log0.delete(); exp_pkt.delete();
        r0 = 1'b0;
        for (int i = 0; i < 20; i++)
            exp_pkt.push_back((i == 0) ? 32'h4000_0100 : (i == 19) ? 32'h8000_0113 : 32'h0000_0100 + i);
        for (int i = 0; i < 16; i++) send(exp_pkt[i]);
        din = exp_pkt[16]; vin = 1'b1;
        repeat (3) cycle();
        chk("bp_ready_low", {31'd0, s_rdy}, 32'd0);
        throttle0 = 1'b1;
        for (int i = 16; i < 20; i++) send(exp_pkt[i]);
        drain(1000);
        throttle0 = 1'b0;
        chk("bp_len", log0.size(), 20);
        if (log0.size() == 20)
            foreach (exp_pkt[i]) chk("bp_flit", log0[i], exp_pkt[i]);

        // head-of-line independence: flee0 full and stalled, flee1 still flows
        r0 = 1'b0; r1 = 1'b1;
        send(32'h4000_0200);
        for (int i = 1; i < 15; i++) send(32'h0000_0200 + i);
        send(32'h8000_020F);
        send(32'hE000_0055);
        cycle();
        chk("hol_v1", {31'd0, s_v1}, 32'd1);
        chk("hol_d1", s_d1, 32'hE000_0055);
        chk("hol_full0", {31'd0, s_v0}, 32'd1);
        r0 = 1'b1;
        drain(100);

        // reset mid-packet
        r0 = 1'b0;
        send(32'h4000_0300); send(32'h0000_0301); send(32'h0000_0302); send(32'h0000_0303);
        rst = 1'b1;
        #1;
        chk("mid_rst_v0", {31'd0, v0}, 32'd0);
        chk("mid_rst_d0", d0, 32'd0);
        chk("mid_rst_v1", {31'd0, v1}, 32'd0);
        chk("mid_rst_ready", {31'd0, rdy_stab}, 32'd0);
        q0.delete(); q1.delete(); mstate = -1; cnt0 = 0; cnt1 = 0; pkts = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        r0 = 1'b1; r1 = 1'b1;
        log0.delete(); log1.delete();
        send(32'h2000_0077);  // body after reset: stray, dropped
        send(32'hE000_0078);
        pkts++;
        idle(3);
        chk("post_rst_len0", log0.size(), 0);
        chk("post_rst_len1", log1.size(), 1);
        if (log1.size() == 1) chk("post_rst_f", log1[0], 32'hE000_0078);

        // randomized traffic against the model
        rand_rdy = 1'b1;
        flits = 0;
        while (flits < 10000) begin
            len = $urandom_range(1, 8);
            dst = $urandom_range(0, 1);
            pay = 29'($urandom);
            if (len == 1) begin
                send({FT_SINGLE, 1'(dst), pay});
            end else begin
                send({FT_HEAD, 1'(dst), pay});
                for (int k = 1; k < len - 1; k++) begin
                    f = $urandom;
                    f[31:30] = ($urandom_range(0, 1) != 0) ? FT_HEAD : FT_BODY;
                    send(f);
                end
                f = $urandom;
                f[31:30] = FT_TAIL;
                send(f);
            end
            flits += len;
            pkts++;
            if ($urandom_range(0, 7) == 0) idle(1);
        end
        rand_rdy = 1'b0;
        r0 = 1'b1; r1 = 1'b1;
        drain(200);
        chk("model_pkts", cnt0 + cnt1, pkts);
`ifdef CIM_PKT_CNT_EN
        chk("pkt_cnt0", pc0, cnt0);
        chk("pkt_cnt1", pc1, cnt1);
        chk("pkt_cnt_sum", pc0 + pc1, pkts);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
